// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR write controller: CSR addresses,
// request encodings, mstatus field positions and the controller state encoding.
package csr_pkg;

    // mstatus value assumed after reset (MPP=M). Reference value only; no logic uses it.
    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MCOUNTEN  = 12'h306;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;

    // Request kinds from execute/commit
    typedef enum logic [1:0] {
        OP_CSR  = 2'b00,
        OP_TRAP = 2'b01,
        OP_MRET = 2'b10,
        OP_RSVD = 2'b11
    } op_kind_e;

    // Zicsr funct3: bit 2 selects the immediate source, bits 1:0 the operation
    localparam int          F3_IMM_BIT = 2;
    localparam logic [1:0]  F3_NONE    = 2'b00;
    localparam logic [1:0]  F3_RW      = 2'b01;
    localparam logic [1:0]  F3_RS      = 2'b10;
    localparam logic [1:0]  F3_RC      = 2'b11;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Controller states
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_CSR         = 4'd1,
        ST_TRAP_EPC    = 4'd2,
        ST_TRAP_CAUSE  = 4'd3,
        ST_TRAP_TVAL   = 4'd4,
        ST_TRAP_STATUS = 4'd5,
        ST_MRET_EPC    = 4'd6,
        ST_MRET_STATUS = 4'd7,
        ST_RSVD        = 4'd8
    } state_e;

    // True for every CSR address present in the CSR file
    function automatic logic csr_implemented(input logic [11:0] addr);
        return addr inside {[CSR_MVENDORID:CSR_MHARTID],
                            CSR_MSTATUS, CSR_MISA,
                            [CSR_MIE:CSR_MCOUNTEN],
                            [CSR_MSCRATCH:CSR_MIP]};
    endfunction

endpackage

// File: rtl/csr_writer_rmw_alu.sv
// Zicsr read-modify-write datapath: computes the new CSR value, whether the
// instruction writes at all, and whether it is an illegal instruction.
module csr_rmw_alu
    import csr_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [11:0] addr,
    input  logic [4:0]  rs1_field,
    input  logic [31:0] rs1_val,
    input  logic [31:0] old_val,
    output logic [31:0] new_val,
    output logic        write,
    output logic        illegal
);

    logic [31:0] src;

    // Source select, RW/RS/RC combine, and legality decode
    always_comb begin
        src     = funct3[F3_IMM_BIT] ? {27'b0, rs1_field} : rs1_val;
        new_val = '0;
        case (funct3[1:0])
            F3_RW:   new_val = src;
            F3_RS:   new_val = old_val | src;
            F3_RC:   new_val = old_val & ~src;
            default: new_val = '0;
        endcase
        // RS/RC with rs1/uimm of zero are pure reads
        write   = (funct3[1:0] == F3_RW) || (rs1_field != 5'd0);
        // Writes to the read-only region (addr[11:10]==11) are illegal
        illegal = (funct3[1:0] == F3_NONE) ||
                  !csr_implemented(addr) ||
                  (write && (addr[11:10] == 2'b11));
    end

endmodule

// File: rtl/csr_writer.sv
// Write-side controller for the machine-mode CSR file. Accepts one request at a
// time, sequences the CSR writes it implies (one per cycle) through the CSR
// file's write port, and reports completion with old value / redirect target.
module csr_writer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_kind,
    input  logic [2:0]  csr_funct3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_field,
    input  logic [31:0] rs1_val,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        done,
    output logic        illegal,
    output logic [31:0] rd_val,
    output logic [31:0] redirect_pc
);

    state_e      state_reg;
    logic [2:0]  funct3_reg;
    logic [11:0] addr_reg;
    logic [4:0]  rs1_field_reg;
    logic [31:0] rs1_val_reg;
    logic [31:0] pc_reg;
    logic [31:0] cause_reg;
    logic [31:0] tval_reg;
    logic [31:0] tgt_reg;

    logic [31:0] alu_new;
    logic        alu_write;
    logic        alu_illegal;
    logic [31:0] status_trap;
    logic [31:0] status_mret;

    csr_rmw_alu u_alu (
        .funct3    (funct3_reg),
        .addr      (addr_reg),
        .rs1_field (rs1_field_reg),
        .rs1_val   (rs1_val_reg),
        .old_val   (csr_rdata),
        .new_val   (alu_new),
        .write     (alu_write),
        .illegal   (alu_illegal)
    );

    // Request capture, redirect-target capture and state sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            funct3_reg    <= '0;
            addr_reg      <= '0;
            rs1_field_reg <= '0;
            rs1_val_reg   <= '0;
            pc_reg        <= '0;
            cause_reg     <= '0;
            tval_reg      <= '0;
            tgt_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (op_valid) begin
                        funct3_reg    <= csr_funct3;
                        addr_reg      <= csr_addr;
                        rs1_field_reg <= rs1_field;
                        rs1_val_reg   <= rs1_val;
                        pc_reg        <= trap_pc;
                        cause_reg     <= trap_cause;
                        tval_reg      <= trap_tval;
                        case (op_kind_e'(op_kind))
                            OP_CSR:  state_reg <= ST_CSR;
                            OP_TRAP: state_reg <= ST_TRAP_EPC;
                            OP_MRET: state_reg <= ST_MRET_EPC;
                            default: state_reg <= ST_RSVD;
                        endcase
                    end
                end
                ST_TRAP_EPC: begin
                    // mtvec is on the read port this cycle; direct mode, word aligned
                    tgt_reg   <= {csr_rdata[31:2], 2'b00};
                    state_reg <= ST_TRAP_CAUSE;
                end
                ST_TRAP_CAUSE:  state_reg <= ST_TRAP_TVAL;
                ST_TRAP_TVAL:   state_reg <= ST_TRAP_STATUS;
                ST_MRET_EPC: begin
                    // mepc is on the read port this cycle
                    tgt_reg   <= csr_rdata;
                    state_reg <= ST_MRET_STATUS;
                end
                default:        state_reg <= ST_IDLE;
            endcase
        end
    end

    // mstatus updates on trap entry and on mret
    always_comb begin
        status_trap                               = csr_rdata;
        status_trap[MSTATUS_MPIE]                 = csr_rdata[MSTATUS_MIE];
        status_trap[MSTATUS_MIE]                  = 1'b0;
        status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        status_mret                               = csr_rdata;
        status_mret[MSTATUS_MIE]                  = csr_rdata[MSTATUS_MPIE];
        status_mret[MSTATUS_MPIE]                 = 1'b1;
        status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // Output decode from state and captured request; reset forces everything quiet
    // so an aborted sequence issues no write or done in the reset cycle itself
    always_comb begin
        op_ready    = 1'b0;
        csr_raddr   = '0;
        csr_we      = 1'b0;
        csr_waddr   = '0;
        csr_wdata   = '0;
        done        = 1'b0;
        illegal     = 1'b0;
        rd_val      = '0;
        redirect_pc = '0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: op_ready = 1'b1;
                ST_CSR: begin
                    csr_raddr = addr_reg;
                    done      = 1'b1;
                    illegal   = alu_illegal;
                    if (!alu_illegal) begin
                        rd_val = csr_rdata;
                        if (alu_write) begin
                            csr_we    = 1'b1;
                            csr_waddr = addr_reg;
                            csr_wdata = alu_new;
                        end
                    end
                end
                ST_TRAP_EPC: begin
                    csr_raddr = CSR_MTVEC;
                    csr_we    = 1'b1;
                    csr_waddr = CSR_MEPC;
                    csr_wdata = {pc_reg[31:2], 2'b00};
                end
                ST_TRAP_CAUSE: begin
                    csr_we    = 1'b1;
                    csr_waddr = CSR_MCAUSE;
                    csr_wdata = cause_reg;
                end
                ST_TRAP_TVAL: begin
                    csr_we    = 1'b1;
                    csr_waddr = CSR_MTVAL;
                    csr_wdata = tval_reg;
                end
                ST_TRAP_STATUS: begin
                    csr_raddr   = CSR_MSTATUS;
                    csr_we      = 1'b1;
                    csr_waddr   = CSR_MSTATUS;
                    csr_wdata   = status_trap;
                    done        = 1'b1;
                    redirect_pc = tgt_reg;
                end
                ST_MRET_EPC: begin
                    csr_raddr = CSR_MEPC;
                end
                ST_MRET_STATUS: begin
                    csr_raddr   = CSR_MSTATUS;
                    csr_we      = 1'b1;
                    csr_waddr   = CSR_MSTATUS;
                    csr_wdata   = status_mret;
                    done        = 1'b1;
                    redirect_pc = tgt_reg;
                end
                ST_RSVD: begin
                    done    = 1'b1;
                    illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
